// File: rtl/tt_display_pkg.sv
// Shared display constants and helpers for the seconds scanner and the
// seven-segment decoder stage.
//   BCD_W          : width of one BCD digit
//   DIGIT_ONES/TENS: digit_sel encodings
//   SEC_TENS_MAX   : largest legal tens digit of a seconds count
//   BCD_MAX        : largest legal BCD digit
//   sec_bcd_inc()  : next seconds value plus a wrap flag
package tt_display_pkg;

  localparam int         BCD_W        = 4;
  localparam logic       DIGIT_ONES   = 1'b0;
  localparam logic       DIGIT_TENS   = 1'b1;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_MAX      = 4'd9;

  // Returns {wrapped, next_bcd}. Only a legal 59 asserts wrapped. An illegal
  // digit (tens above 5 or ones above 9) restarts the count at 00 silently.
  function automatic logic [8:0] sec_bcd_inc(input logic [7:0] cur);
    logic [3:0] tens;
    logic [3:0] ones;
    logic [8:0] res;
    tens = cur[7:4];
    ones = cur[3:0];
    if ((tens > SEC_TENS_MAX) || (ones > BCD_MAX)) begin
      res = 9'h000;
    end else if ((tens == SEC_TENS_MAX) && (ones == BCD_MAX)) begin
      res = 9'h100;
    end else if (ones == BCD_MAX) begin
      res = {1'b0, tens + 4'd1, 4'd0};
    end else begin
      res = {1'b0, tens, ones + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/seconds_bcd_scanner_mod_n_counter.sv
// Modulo-N counter with enable and synchronous clear.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   en    : advance the count
//   clr   : synchronous clear to 0, overrides en
//   count : current count, 0..N-1
//   wrap  : combinational, high when the next enabled edge returns count to 0
module mod_n_counter #(
  parameter int N = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic                                clr,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] count,
  output logic                                wrap
);
  import tt_display_pkg::*;

  localparam int         W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Terminal count while enabled; clr does not mask it, the owner decides.
  assign wrap  = en && (count_q == LAST);
  assign count = count_q;

  // Next-count selection: clear, wrap, increment or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (wrap) begin
      count_d = {W{1'b0}};
    end else if (en) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seconds_bcd_scanner.sv
// Seconds counter with two-digit BCD scan output.
//   clk         : system clock
//   rst         : asynchronous active-high reset
//   run         : 1 = prescaler advances, 0 = prescaler and count hold
//   clear       : synchronous clear of count and prescaler, beats run
//   tick        : one-cycle pulse per elapsed second (registered)
//   rollover    : one-cycle pulse when the count wraps 59 -> 00 (registered)
//   seconds_bcd : {tens, ones} (registered)
//   digit_sel   : 0 = ones shown, 1 = tens shown (registered)
//   digit_bcd   : selected digit, combinational from registered state
module seconds_bcd_scanner #(
  parameter int MAX_COUNT = 16_000_000,
  parameter int MUX_COUNT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  output logic       tick,
  output logic       rollover,
  output logic [7:0] seconds_bcd,
  output logic       digit_sel,
  output logic [3:0] digit_bcd
);
  import tt_display_pkg::*;

  localparam int PRE_W = $clog2(MAX_COUNT);
  localparam int MUX_W = (MUX_COUNT > 1) ? $clog2(MUX_COUNT) : 1;

  logic [PRE_W-1:0] pre_count_unused;
  logic [MUX_W-1:0] mux_count_unused;
  logic             pre_wrap;
  logic             mux_wrap;

  logic       tick_q, tick_d;
  logic       rollover_q, rollover_d;
  logic [7:0] seconds_q, seconds_d;
  logic       digit_sel_q, digit_sel_d;
  logic [8:0] inc_s;

  mod_n_counter #(.N(MAX_COUNT)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .clr   (clear),
    .count (pre_count_unused),
    .wrap  (pre_wrap)
  );

  // The scan counter is never gated, so the display keeps refreshing
  // while the count is paused or cleared.
  mod_n_counter #(.N(MUX_COUNT)) u_scan (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .clr   (1'b0),
    .count (mux_count_unused),
    .wrap  (mux_wrap)
  );

  assign inc_s = sec_bcd_inc(seconds_q);

  // Seconds, tick and rollover next state; clear wins over a coincident tick.
  always_comb begin
    tick_d     = 1'b0;
    rollover_d = 1'b0;
    seconds_d  = seconds_q;
    if (clear) begin
      seconds_d = 8'h00;
    end else if (pre_wrap) begin
      tick_d     = 1'b1;
      rollover_d = inc_s[8];
      seconds_d  = inc_s[7:0];
    end else begin
      seconds_d = seconds_q;
    end
  end

  // Digit select flips each time the scan counter wraps.
  always_comb begin
    digit_sel_d = digit_sel_q;
    if (mux_wrap) begin
      digit_sel_d = ~digit_sel_q;
    end else begin
      digit_sel_d = digit_sel_q;
    end
  end

  // Output and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q      <= 1'b0;
      rollover_q  <= 1'b0;
      seconds_q   <= 8'h00;
      digit_sel_q <= DIGIT_ONES;
    end else begin
      tick_q      <= tick_d;
      rollover_q  <= rollover_d;
      seconds_q   <= seconds_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign tick        = tick_q;
  assign rollover    = rollover_q;
  assign seconds_bcd = seconds_q;
  assign digit_sel   = digit_sel_q;
  // Zero-latency select so the decoder sees a new count on the cycle it lands.
  assign digit_bcd   = (digit_sel_q == DIGIT_TENS) ? seconds_q[7:4] : seconds_q[3:0];

endmodule

// File: tb/tb_seconds_bcd_scanner.sv
// Self-checking bench for seconds_bcd_scanner (MAX_COUNT=100, MUX_COUNT=4).
// A decimal reference model (seconds as an integer 0..59) predicts every cycle.
module tb_seconds_bcd_scanner;

  localparam int MAXC = 100;
  localparam int MUXC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       clear;
  logic       tick;
  logic       rollover;
  logic [7:0] seconds_bcd;
  logic       digit_sel;
  logic [3:0] digit_bcd;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_sec, m_pre, m_mux, edge_n;
  bit m_tick, m_roll, m_sel;

  seconds_bcd_scanner #(.MAX_COUNT(MAXC), .MUX_COUNT(MUXC)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .clear       (clear),
    .tick        (tick),
    .rollover    (rollover),
    .seconds_bcd (seconds_bcd),
    .digit_sel   (digit_sel),
    .digit_bcd   (digit_bcd)
  );

  always #5 clk = ~clk;

  wire [14:0] obs = {tick, rollover, seconds_bcd, digit_sel, digit_bcd};

  function automatic logic [14:0] expv();
    logic [3:0] t, o;
    t = 4'(m_sec / 10);
    o = 4'(m_sec % 10);
    return {m_tick, m_roll, t, o, m_sel, (m_sel ? t : o)};
  endfunction

  task automatic model_reset();
    m_sec = 0; m_pre = 0; m_mux = 0;
    m_tick = 1'b0; m_roll = 1'b0; m_sel = 1'b0;
  endtask

  task automatic model_step();
    if (clear) begin
      m_pre = 0; m_sec = 0; m_tick = 1'b0; m_roll = 1'b0;
    end else if (run) begin
      if (m_pre == MAXC - 1) begin
        m_pre = 0;
        m_tick = 1'b1;
        m_roll = (m_sec == 59);
        m_sec = (m_sec + 1) % 60;
      end else begin
        m_pre++; m_tick = 1'b0; m_roll = 1'b0;
      end
    end else begin
      m_tick = 1'b0; m_roll = 1'b0;
    end
    if (m_mux == MUXC - 1) begin
      m_mux = 0; m_sel = !m_sel;
    end else begin
      m_mux++;
    end
  endtask

  // One rising edge; model advances on the same edge; return 1 ns later.
  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL reset_async got=%h exp=%h", obs, 15'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", obs, 15'd0);
    end
    @(negedge clk);
    rst = 1'b0; run = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_basic_count();
    while (edge_n < 1100) begin
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL basic_cycle edge=%0d got=%h exp=%h", edge_n, obs, expv());
      end
      if (edge_n == 100) begin
        checks++;
        if ({tick, seconds_bcd} !== {1'b1, 8'h01}) begin
          errors++; $display("FAIL basic_first_tick got=%b/%h exp=1/01", tick, seconds_bcd);
        end
      end
      if (edge_n == 101) begin
        checks++;
        if (tick !== 1'b0) begin
          errors++; $display("FAIL basic_tick_width got=%b exp=0", tick);
        end
      end
      if (edge_n == 1000) begin
        checks++;
        if (seconds_bcd !== 8'h10) begin
          errors++; $display("FAIL basic_edge1000 got=%h exp=10", seconds_bcd);
        end
      end
      if (edge_n == 1100) begin
        checks++;
        if (seconds_bcd !== 8'h11) begin
          errors++; $display("FAIL basic_edge1100 got=%h exp=11", seconds_bcd);
        end
      end
    end
  endtask

  task automatic test_rollover();
    int roll_cnt = 0;
    while (edge_n < 6000) begin
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL roll_cycle edge=%0d got=%h exp=%h", edge_n, obs, expv());
      end
      if (rollover === 1'b1) roll_cnt++;
      if (edge_n == 5900) begin
        checks++;
        if (seconds_bcd !== 8'h59) begin
          errors++; $display("FAIL roll_edge5900 got=%h exp=59", seconds_bcd);
        end
      end
      if (edge_n == 6000) begin
        checks++;
        if ({tick, rollover, seconds_bcd} !== {1'b1, 1'b1, 8'h00}) begin
          errors++; $display("FAIL roll_edge6000 got=%b%b/%h exp=11/00", tick, rollover, seconds_bcd);
        end
      end
    end
    checks++;
    if (roll_cnt != 1) begin
      errors++; $display("FAIL roll_pulse_count got=%0d exp=1", roll_cnt);
    end
  endtask

  task automatic test_pause();
    logic [7:0] held;
    int n;
    n = 0;
    while (m_pre != 50 && n < 200) begin
      cyc(); n++;
    end
    held = seconds_bcd;
    run = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if ({tick, seconds_bcd} !== {1'b0, held} || obs !== expv()) begin
        errors++; $display("FAIL pause_hold i=%0d got=%b/%h exp=0/%h", i, tick, seconds_bcd, held);
      end
    end
    run = 1'b1;
    n = 0;
    do begin
      cyc(); n++;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL pause_resume_cycle n=%0d got=%h exp=%h", n, obs, expv());
      end
    end while (tick !== 1'b1 && n < 200);
    checks++;
    if (n != 50) begin
      errors++; $display("FAIL pause_next_tick got=%0d edges exp=50", n);
    end
  endtask

  task automatic test_clear_priority();
    int n;
    run = 1'b1;
    n = 0;
    while (!(m_sec == 37 && m_pre == 99) && n < 7000) begin
      cyc(); n++;
    end
    checks++;
    if (seconds_bcd !== 8'h37) begin
      errors++; $display("FAIL clear_setup got=%h exp=37", seconds_bcd);
    end
    clear = 1'b1;
    cyc();
    checks++;
    if ({tick, rollover, seconds_bcd} !== {1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL clear_wins got=%b%b/%h exp=00/00", tick, rollover, seconds_bcd);
    end
    clear = 1'b0;
    n = 0;
    do begin
      cyc(); n++;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL clear_after_cycle n=%0d got=%h exp=%h", n, obs, expv());
      end
    end while (tick !== 1'b1 && n < 300);
    checks++;
    if (n != 100) begin
      errors++; $display("FAIL clear_next_tick got=%0d edges exp=100", n);
    end
  endtask

  task automatic test_scan();
    int n, last_t;
    logic prev;
    run = 1'b1;
    n = 0;
    while (m_sec != 42 && n < 7000) begin
      cyc(); n++;
    end
    run = 1'b0;
    last_t = -1;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) clear = 1'b1;
      if (i == 15) clear = 1'b0;
      prev = digit_sel;
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL scan_cycle i=%0d got=%h exp=%h", i, obs, expv());
      end
      if (i < 12) begin
        checks++;
        if (digit_bcd !== (digit_sel ? 4'd4 : 4'd2)) begin
          errors++; $display("FAIL scan_digit sel=%b got=%0d exp=%0d", digit_sel, digit_bcd, digit_sel ? 4 : 2);
        end
      end
      if (digit_sel !== prev) begin
        if (last_t >= 0) begin
          checks++;
          if (edge_n - last_t != MUXC) begin
            errors++; $display("FAIL scan_cadence got=%0d exp=%0d", edge_n - last_t, MUXC);
          end
        end
        last_t = edge_n;
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    run = 1'b1;
    n = 0;
    while (m_sec != 25 && n < 7000) begin
      cyc(); n++;
    end
    checks++;
    if (seconds_bcd !== 8'h25) begin
      errors++; $display("FAIL areset_setup got=%h exp=25", seconds_bcd);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL areset_immediate got=%h exp=%h", obs, 15'd0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (obs !== 15'd0) begin
      errors++; $display("FAIL areset_released got=%h exp=%h", obs, 15'd0);
    end
    model_reset();
    edge_n = 0;
    n = 0;
    do begin
      cyc(); n++;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL areset_cycle n=%0d got=%h exp=%h", n, obs, expv());
      end
    end while (tick !== 1'b1 && n < 300);
    checks++;
    if (n != 100 || seconds_bcd !== 8'h01) begin
      errors++; $display("FAIL areset_first_tick got=%0d/%h exp=100/01", n, seconds_bcd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      run   = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 299) == 0);
      cyc();
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random_cycle i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    edge_n = 0;
    test_reset();
    test_basic_count();
    test_rollover();
    test_pause();
    test_clear_priority();
    test_scan();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seconds_bcd_scanner.md
Name: seconds_bcd_scanner

Overview:
- Upstream stage of the seven-segment decoder: turns the board clock into a seconds count and presents one BCD digit at a time for decoding.
- Prescales clk to a 1 s tick and counts seconds 00–59 in BCD.
- Time-multiplexes ones/tens digits onto a 4-bit bus with a digit-select line, so one decoder drives a two-digit display.
- Sits inside the 8-in/8-out project wrapper; clk and rst arrive on io_in[0]/io_in[1].

Parameters:
- MAX_COUNT, 16_000_000: clk cycles per second tick; benches use 100; must be >= 2.
- MUX_COUNT, 1000: clk cycles per displayed digit before digit_sel toggles; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- run  input  1  1 = prescaler advances; 0 = prescaler and count hold.
- clear  input  1  synchronous clear of count and prescaler; priority over run.
- tick  output  1  one-cycle pulse per elapsed second.
- rollover  output  1  one-cycle pulse when count wraps 59 -> 00.
- seconds_bcd  output  8  {tens[3:0], ones[3:0]}, registered.
- digit_sel  output  1  0 = ones digit shown, 1 = tens digit shown.
- digit_bcd  output  4  BCD of the selected digit, i.e. the decoder input.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst); all state updates on rising clk.
- Reset: prescaler=0, mux counter=0; tick=0, rollover=0, seconds_bcd=8'h00, digit_sel=0, digit_bcd=0. Takes effect immediately, without a clock edge.
- Prescaler:
  - Width $clog2(MAX_COUNT); counts 0..MAX_COUNT-1.
  - If run=1 and prescaler==MAX_COUNT-1: prescaler<=0, tick<=1 and the count increments on the same edge, so tick and the new count are visible together.
  - Otherwise, if run=1: prescaler<=prescaler+1 and tick<=0.
  - If run=0: prescaler holds and tick<=0.
  - With run held at 1 from reset release, the first tick is registered on the MAX_COUNT-th rising edge.
- Count increment:
  - ones 0..8 -> ones+1.
  - ones 9 -> ones=0 and tens+1.
  - tens=5 with ones=9 -> 8'h00, and rollover<=1 on that same edge; otherwise rollover<=0.
  - Codes above 5/9 are unreachable. If forced, the next increment goes to 8'h00 and does not assert rollover.
- Clear: when clear=1, on the next edge prescaler<=0, seconds_bcd<=8'h00, tick<=0 and rollover<=0, regardless of run or a coincident terminal count. The mux counter is unaffected.
- Mux:
  - Free-running regardless of run and clear; counts 0..MUX_COUNT-1.
  - At MUX_COUNT-1 it wraps to 0 and digit_sel toggles.
  - MUX_COUNT=1 toggles digit_sel every cycle.
- digit_bcd: combinational select of registered values, digit_sel ? tens : ones. It reflects a count change in the same cycle the count changes (zero latency).
- Reset mid-operation: asynchronous clear of everything; counting restarts from prescaler=0 after release.

Decomposition:
- Shared package tt_display_pkg:
  - BCD_W=4.
  - DIGIT_ONES=1'b0, DIGIT_TENS=1'b1.
  - SEC_TENS_MAX=4'd5, BCD_MAX=4'd9.
  - Shared with the seven-segment decoder stage.
- One sub-module, mod_n_counter:
  - Parameter N; ports clk, rst, en, clr, count, wrap.
  - Instantiated twice: prescaler (en=run, clr=clear) and digit-scan counter (en=1, clr=0).

Test Plan:
- Basic count: MAX_COUNT=100, run=1 from reset release. Edge 100 -> tick=1 for exactly one cycle and seconds_bcd=8'h01. Edge 1000 -> 8'h10. Edge 1100 -> 8'h11.
- Rollover: run 6000 edges. At edge 5900 seconds_bcd=8'h59. At edge 6000 seconds_bcd=8'h00 with tick=1 and rollover=1 in the same single cycle. No other cycle shows rollover=1.
- Pause: drop run at prescaler=50 for 30 cycles -> tick stays 0 and the count holds. Next tick arrives 50 edges after run returns to 1.
- Clear priority: at seconds_bcd=8'h37 with prescaler=99, assert clear=1 and run=1 together. Next edge -> seconds_bcd=8'h00, tick=0, prescaler=0. Next tick is 100 edges later.
- Scan: MUX_COUNT=4, seconds_bcd=8'h42, run=0. digit_sel toggles every 4 edges; digit_bcd alternates 2 (sel=0) and 4 (sel=1). Asserting clear does not disturb the toggle cadence.
- Async reset: pulse rst for 3 ns between edges at seconds_bcd=8'h25 -> all outputs read 0 before the next rising edge. After release, first tick occurs at edge 100.
